// File: rtl/exu_pkg.sv
// Shared opcode constants and enumerations for the execute unit and its
// iterative multiply/divide core.
package exu_pkg;

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_ARITH  = 7'b0010011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] FUNC7_MDU     = 7'b0000001;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_EQ
    } aluop_e;

    // Encoding order matches func3 so a plain cast decodes the M op.
    typedef enum logic [2:0] {
        MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
        MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU
    } mdu_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

endpackage

// File: rtl/mdu_iter.sv
// Iterative M-extension core: shift-add multiply and restoring divide on
// operand magnitudes, one bit per cycle, with sign fix-up on the way out.
module mdu_iter
    import exu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  mdu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            last_o,
    output logic [XLEN-1:0] result_o
);

    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              run_q, is_div_q, hi_q, rem_q, neg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q, mcand_q, acc_step, full;
    logic [XLEN-1:0]   mplier_q, sel;
    logic [XLEN:0]     trial, diff;

    always_comb begin
        a_neg = (op_i inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM}) && a_i[XLEN-1];
        b_neg = (op_i inside {MDU_MULH, MDU_DIV, MDU_REM}) && b_i[XLEN-1];
        a_mag = a_neg ? -a_i : a_i;
        b_mag = b_neg ? -b_i : b_i;
    end

    // Divide keeps {remainder, dividend/quotient} in acc_q and the divisor in mcand_q.
    always_comb begin
        trial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff  = trial - {1'b0, mcand_q[XLEN-1:0]};
        if (is_div_q) begin
            if (!diff[XLEN]) acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            else             acc_step = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
            acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;
        end
    end

    assign last_o = run_q && (cnt_q == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            hi_q     <= 1'b0;
            rem_q    <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start_i) begin
            run_q    <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= op_i[2];
            hi_q     <= (op_i != MDU_MUL);
            rem_q    <= op_i[1];
            neg_q    <= (op_i[2] && op_i[1]) ? a_neg : (a_neg ^ b_neg);
            acc_q    <= op_i[2] ? {{XLEN{1'b0}}, a_mag} : '0;
            mcand_q  <= op_i[2] ? {{XLEN{1'b0}}, b_mag} : {{XLEN{1'b0}}, a_mag};
            mplier_q <= b_mag;
        end else if (run_q) begin
            acc_q    <= acc_step;
            cnt_q    <= cnt_q + CNT_W'(1);
            mplier_q <= mplier_q >> 1;
            if (!is_div_q) mcand_q <= mcand_q << 1;
            if (last_o) run_q <= 1'b0;
        end
    end

    always_comb begin
        full = neg_q ? -acc_q : acc_q;
        sel  = rem_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (is_div_q) result_o = neg_q ? -sel : sel;
        else          result_o = hi_q ? full[2*XLEN-1:XLEN] : full[XLEN-1:0];
    end

endmodule

// File: rtl/exu_mdu.sv
// Execute unit: ALU decode plus iterative multiply/divide behind
// valid/ready handshakes on the IDU and LSU/WBU sides.
//   state | meaning
//   IDLE  | in_ready high, waiting for an operation
//   BUSY  | mdu_iter iterating, inputs ignored
//   DONE  | out_valid high, res held until out_ready
module exu_mdu
    import exu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      opcode,
    input  logic [2:0]      func3,
    input  logic [6:0]      func7,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] res,
    output logic            busy
);

    localparam int              SH_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

    state_e          state_q, state_d;
    logic [XLEN-1:0] res_q, res_d, alu_res, spec_res, mdu_res;
    logic            mdu_sel_q, mdu_sel_d;
    aluop_e          aluop;
    logic            is_branch, cmp_inv, is_m, div_zero, div_ovf, spec_hit;
    logic            start, mdu_last;
    logic [SH_W-1:0] shamt;

    always_comb begin
        aluop     = ALU_ADD;
        is_branch = (opcode == OPCODE_BRANCH);
        cmp_inv   = 1'b0;
        if (is_branch) begin
            cmp_inv = func3[0];
            case (func3[2:1])
                2'b10:   aluop = ALU_SLT;
                2'b11:   aluop = ALU_SLTU;
                default: aluop = ALU_EQ;
            endcase
        end else if (opcode == OPCODE_R || opcode == OPCODE_ARITH) begin
            case (func3)
                3'b000:  aluop = (opcode == OPCODE_R && func7[5]) ? ALU_SUB : ALU_ADD;
                3'b001:  aluop = ALU_SLL;
                3'b010:  aluop = ALU_SLT;
                3'b011:  aluop = ALU_SLTU;
                3'b100:  aluop = ALU_XOR;
                3'b101:  aluop = func7[5] ? ALU_SRA : ALU_SRL;
                3'b110:  aluop = ALU_OR;
                default: aluop = ALU_AND;
            endcase
        end
    end

    always_comb begin
        shamt = op2[SH_W-1:0];
        case (aluop)
            ALU_SUB:  alu_res = op1 - op2;
            ALU_SLL:  alu_res = op1 << shamt;
            ALU_SLT:  alu_res = XLEN'($signed(op1) < $signed(op2));
            ALU_SLTU: alu_res = XLEN'(op1 < op2);
            ALU_XOR:  alu_res = op1 ^ op2;
            ALU_SRL:  alu_res = op1 >> shamt;
            ALU_SRA:  alu_res = $signed(op1) >>> shamt;
            ALU_OR:   alu_res = op1 | op2;
            ALU_AND:  alu_res = op1 & op2;
            ALU_EQ:   alu_res = XLEN'(op1 == op2);
            default:  alu_res = op1 + op2;
        endcase
        if (is_branch) alu_res[0] = alu_res[0] ^ cmp_inv;
    end

    // Divide-by-zero and signed overflow finish without iterating.
    always_comb begin
        is_m     = (opcode == OPCODE_R) && (func7 == FUNC7_MDU);
        div_zero = func3[2] && (op2 == '0);
        div_ovf  = func3[2] && !func3[0] && (op1 == XMIN) && (op2 == '1);
        spec_hit = div_zero || div_ovf;
        if (div_zero) spec_res = func3[1] ? op1 : '1;
        else          spec_res = func3[1] ? '0 : XMIN;
    end

    mdu_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start),
        .op_i     (mdu_op_e'(func3)),
        .a_i      (op1),
        .b_i      (op2),
        .last_o   (mdu_last),
        .result_o (mdu_res)
    );

    always_comb begin
        state_d   = state_q;
        res_d     = res_q;
        mdu_sel_d = mdu_sel_q;
        start     = 1'b0;
        case (state_q)
            ST_IDLE: if (in_valid) begin
                if (is_m && !spec_hit) begin
                    start     = 1'b1;
                    mdu_sel_d = 1'b1;
                    state_d   = ST_BUSY;
                end else begin
                    res_d     = is_m ? spec_res : alu_res;
                    mdu_sel_d = 1'b0;
                    state_d   = ST_DONE;
                end
            end
            ST_BUSY: if (mdu_last) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            res_q     <= '0;
            mdu_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            res_q     <= res_d;
            mdu_sel_q <= mdu_sel_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_BUSY);
    assign res       = mdu_sel_q ? mdu_res : res_q;

endmodule

// File: tb/tb_exu_mdu.sv
// Directed bench for exu_mdu: expected result/latency pushed to a scoreboard
// at issue, popped and compared when out_valid appears.
module tb_exu_mdu;
    import exu_pkg::*;

    localparam int XLEN = 32;
    localparam logic [6:0] F7_0   = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;
    localparam logic [6:0] F7_M   = 7'b0000001;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid, in_ready, out_valid, out_ready, busy;
    logic [6:0]      opcode, func7;
    logic [2:0]      func3;
    logic [XLEN-1:0] op1, op2, res;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          bsy;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    exu_mdu #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .func3     (func3),
        .func7     (func7),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input int elat, input int ebsy, input int hold);
        exp_t x;
        int   lat;
        int   bcnt;
        x.res = e;
        x.lat = elat;
        x.bsy = ebsy;
        sb.push_back(x);
        @(negedge clk);
        in_valid  = 1'b1;
        opcode    = opc;
        func3     = f3;
        func7     = f7;
        op1       = a;
        op2       = b;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        lat  = 0;
        bcnt = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (out_valid) break;
        end
        x = sb.pop_front();
        chk({tag, "_res"}, res, x.res);
        chk({tag, "_lat"}, 32'(lat), 32'(x.lat));
        chk({tag, "_busy"}, 32'(bcnt), 32'(x.bsy));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "_hold_res"}, res, x.res);
            chk({tag, "_hold_rdy"}, {31'b0, in_ready}, 32'd0);
            chk({tag, "_hold_vld"}, {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
        opcode    = '0;
        func3     = '0;
        func7     = '0;
        op1       = '0;
        op2       = '0;
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_res", res, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sub",   OPCODE_R,      3'b000, F7_SUB, 32'd5,        32'd7,        32'hFFFF_FFFE, 1, 0, 0);
        run_op("addi",  OPCODE_ARITH,  3'b000, F7_SUB, 32'd10,       32'h400,      32'h0000_040A, 1, 0, 0);
        run_op("sra",   OPCODE_R,      3'b101, F7_SUB, 32'h8000_0000, 32'd4,       32'hF800_0000, 1, 0, 0);
        run_op("srl",   OPCODE_R,      3'b101, F7_0,   32'h8000_0000, 32'd4,       32'h0800_0000, 1, 0, 0);
        run_op("slli",  OPCODE_ARITH,  3'b001, F7_0,   32'd1,        32'h3F,       32'h8000_0000, 1, 0, 0);
        run_op("slt",   OPCODE_R,      3'b010, F7_0,   32'hFFFF_FFFF, 32'd1,       32'd1,         1, 0, 0);
        run_op("lui",   OPCODE_LUI,    3'b000, F7_0,   32'd0,        32'h1234_5000, 32'h1234_5000, 1, 0, 0);
        run_op("bne",   OPCODE_BRANCH, 3'b001, F7_0,   32'd3,        32'd3,        32'd0,         1, 0, 0);
        run_op("beq",   OPCODE_BRANCH, 3'b000, F7_0,   32'd3,        32'd3,        32'd1,         1, 0, 0);
        run_op("bgeu",  OPCODE_BRANCH, 3'b111, F7_0,   32'd1,        32'hFFFF_FFFF, 32'd0,        1, 0, 0);
        run_op("blt",   OPCODE_BRANCH, 3'b100, F7_0,   32'hFFFF_FFFF, 32'd1,       32'd1,         1, 0, 0);

        run_op("mulh",   OPCODE_R, 3'b001, F7_M, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, 32, 0);
        run_op("mulhu",  OPCODE_R, 3'b011, F7_M, 32'hFFFF_FFFE, 32'd3, 32'h0000_0002, 33, 32, 0);
        run_op("mulhsu", OPCODE_R, 3'b010, F7_M, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 33, 32, 0);
        run_op("mul",    OPCODE_R, 3'b000, F7_M, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 33, 32, 0);

        run_op("div0",  OPCODE_R, 3'b100, F7_M, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
        run_op("rem0",  OPCODE_R, 3'b110, F7_M, 32'd7, 32'd0, 32'd7,         1, 0, 0);
        run_op("divu0", OPCODE_R, 3'b101, F7_M, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
        run_op("divov", OPCODE_R, 3'b100, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
        run_op("remov", OPCODE_R, 3'b110, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0, 0);

        run_op("div",   OPCODE_R, 3'b100, F7_M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32, 0);
        run_op("rem",   OPCODE_R, 3'b110, F7_M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 32, 0);
        run_op("remu",  OPCODE_R, 3'b111, F7_M, 32'd100,       32'd7, 32'd2,         33, 32, 0);
        run_op("divu_hold", OPCODE_R, 3'b101, F7_M, 32'd100,   32'd7, 32'd14,        33, 32, 10);

        // Abandon a multiply partway through with an asynchronous reset.
        @(negedge clk);
        in_valid = 1'b1;
        opcode   = OPCODE_R;
        func3    = 3'b011;
        func7    = F7_M;
        op1      = 32'hFFFF_FFFE;
        op2      = 32'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("midbusy_busy", {31'b0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_res", res, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("div_after_rst", OPCODE_R, 3'b100, F7_M, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 32, 0);
        run_op("add_after_rst", OPCODE_R, 3'b000, F7_0, 32'd40,        32'd2, 32'd42,        1,  0,  0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
